// File: rtl/mstage_lsu_if.sv
// AXI4-Lite data-memory channel between the M-stage load/store unit (master)
// and data memory or its interconnect (slave).
interface mstage_lsu_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/mstage_lsu.sv
// Memory-stage load/store unit: one instruction per handshake, AXI4-Lite data access,
// load extension/lane select. Bus-error reporting enabled by CONFIG_LSU_FAULT_EN.
//
// state | meaning
// IDLE  | ready to accept an instruction from the E stage
// AR    | read address presented, waiting for arready
// R     | waiting for read data
// AW_W  | write address and data presented, each retires on its own ready
// B     | waiting for write response
// DONE  | result presented to Wstage_bus, held until m_ready
module mstage_lsu #(
   parameter int PASS_W = 146
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              memrdE,
   input  logic              memwrE,
   input  logic [2:0]        funct3E,
   input  logic [31:0]       ALU_resultE,
   input  logic [31:0]       src2E,
   input  logic [PASS_W-1:0] ctrlE,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [31:0]       mdataM,
   output logic [31:0]       ALU_resultM,
   output logic [31:0]       src2M,
   output logic [PASS_W-1:0] ctrlM,
   output logic              faultM,
   mstage_lsu_if.master      axi
);
   typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} state_t;

   state_t      state, state_nxt;
   logic        accept;
   logic [2:0]  funct3_q;
   logic        aw_done, w_done;
   logic [31:0] wdata_q, store_data;
   logic [3:0]  wstrb_q, store_strb;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_ext;

   assign accept = (state == IDLE) && s_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (s_valid) state_nxt = memrdE ? AR : (memwrE ? AW_W : DONE);
         AR:   if (axi.arready) state_nxt = R;
         R:    if (axi.rvalid) state_nxt = DONE;
         AW_W: if ((aw_done || axi.awready) && (w_done || axi.wready)) state_nxt = B;
         B:    if (axi.bvalid) state_nxt = DONE;
         DONE: if (m_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_ready     = (state == IDLE);
      m_valid     = (state == DONE);
      axi.arvalid = (state == AR);
      axi.rready  = (state == R);
      axi.awvalid = (state == AW_W) && !aw_done;
      axi.wvalid  = (state == AW_W) && !w_done;
      axi.bready  = (state == B);
      axi.araddr  = ALU_resultM;
      axi.awaddr  = ALU_resultM;
      axi.wdata   = wdata_q;
      axi.wstrb   = wstrb_q;
   end

   // Store data/strobes are formed at accept so they are stable for the whole AW_W phase.
   always_comb begin
      case (funct3E[1:0])
         2'b00: begin
            store_data = {4{src2E[7:0]}};
            store_strb = 4'b0001 << ALU_resultE[1:0];
         end
         2'b01: begin
            store_data = {2{src2E[15:0]}};
            store_strb = 4'b0011 << {ALU_resultE[1], 1'b0};
         end
         default: begin
            store_data = src2E;
            store_strb = 4'b1111;
         end
      endcase
   end

   always_comb begin
      case (ALU_resultM[1:0])
         2'd0:    lane_b = axi.rdata[7:0];
         2'd1:    lane_b = axi.rdata[15:8];
         2'd2:    lane_b = axi.rdata[23:16];
         default: lane_b = axi.rdata[31:24];
      endcase
      lane_h = ALU_resultM[1] ? axi.rdata[31:16] : axi.rdata[15:0];
      case (funct3_q)
         3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
         3'b100:  load_ext = {24'd0, lane_b};
         3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
         3'b101:  load_ext = {16'd0, lane_h};
         default: load_ext = axi.rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ALU_resultM <= '0;
         src2M       <= '0;
         ctrlM       <= '0;
         funct3_q    <= '0;
         mdataM      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
      end else begin
         if (accept) begin
            ALU_resultM <= ALU_resultE;
            src2M       <= src2E;
            ctrlM       <= ctrlE;
            funct3_q    <= funct3E;
            mdataM      <= '0;
            wdata_q     <= memwrE ? store_data : 32'd0;
            wstrb_q     <= memwrE ? store_strb : 4'd0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
         end
         if (state == R && axi.rvalid) begin
`ifdef CONFIG_LSU_FAULT_EN
            mdataM <= (axi.rresp != 2'b00) ? 32'd0 : load_ext;
`else
            mdataM <= load_ext;
`endif
         end
         if (state == AW_W) begin
            if (axi.awready) aw_done <= 1'b1;
            if (axi.wready)  w_done  <= 1'b1;
         end
      end
   end

`ifdef CONFIG_LSU_FAULT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         faultM <= 1'b0;
      end else begin
         if (accept)                        faultM <= 1'b0;
         else if (state == R && axi.rvalid) faultM <= (axi.rresp != 2'b00);
         else if (state == B && axi.bvalid) faultM <= (axi.bresp != 2'b00);
      end
   end
`else
   assign faultM = 1'b0;
`endif
endmodule

// File: tb/tb_mstage_lsu.sv
// Randomized bench for mstage_lsu: the bench acts as AXI4-Lite slave with random
// wait states and checks results against a spec-level reference model.
module tb_mstage_lsu;
   localparam int PASS_W = 146;

   logic              clk, rst;
   logic              s_valid, s_ready;
   logic              memrdE, memwrE;
   logic [2:0]        funct3E;
   logic [31:0]       ALU_resultE, src2E;
   logic [PASS_W-1:0] ctrlE;
   logic              m_valid, m_ready;
   logic [31:0]       mdataM, ALU_resultM, src2M;
   logic [PASS_W-1:0] ctrlM;
   logic              faultM;

   mstage_lsu_if axi();

   mstage_lsu #(.PASS_W(PASS_W)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready),
      .memrdE(memrdE), .memwrE(memwrE), .funct3E(funct3E),
      .ALU_resultE(ALU_resultE), .src2E(src2E), .ctrlE(ctrlE),
      .m_valid(m_valid), .m_ready(m_ready),
      .mdataM(mdataM), .ALU_resultM(ALU_resultM), .src2M(src2M),
      .ctrlM(ctrlM), .faultM(faultM),
      .axi(axi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] d);
      longint b, h;
      b = (d >> (8 * a[1:0])) & 32'hFF;
      h = (d >> (16 * a[1])) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 128) ? 32'(b - 256) : 32'(b);
         3'b100:  return 32'(b);
         3'b001:  return (h >= 32768) ? 32'(h - 65536) : 32'(h);
         3'b101:  return 32'(h);
         default: return d;
      endcase
   endfunction

   task automatic slave_idle();
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0;
   endtask

   // kind: 0 non-memory, 1 load, 2 store
   task automatic run_op(input int kind, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] s2, input logic [31:0] rd, input logic [1:0] resp,
                         input int ar_d, input int r_d, input int aw_d, input int w_d,
                         input int b_d, input int stall);
      logic [PASS_W-1:0] ctl;
      logic [31:0] exp_md, exp_wd;
      logic [3:0]  exp_ws;
      logic        exp_f;
      int exp_lat, cyc, arv_n, r_n, awv_n, wv_n, b_n;

      ctl = PASS_W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      exp_md = (kind == 1) ? ref_load(f3, a, rd) : 32'd0;
      exp_f  = 1'b0;
`ifdef CONFIG_LSU_FAULT_EN
      if (kind != 0 && resp != 2'b00) exp_f = 1'b1;
      if (kind == 1 && resp != 2'b00) exp_md = 32'd0;
`endif
      case (f3[1:0])
         2'b00:   begin exp_wd = (s2 & 32'hFF) * 32'h01010101;   exp_ws = 4'(1 << a[1:0]); end
         2'b01:   begin exp_wd = (s2 & 32'hFFFF) * 32'h00010001; exp_ws = 4'(3 << (2 * a[1])); end
         default: begin exp_wd = s2; exp_ws = 4'hF; end
      endcase
      if (kind == 0)      exp_lat = 1;
      else if (kind == 1) exp_lat = 3 + ar_d + r_d;
      else                exp_lat = 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d;

      chk("s_ready_idle", s_ready, 1);
      s_valid = 1'b1; memrdE = (kind == 1); memwrE = (kind == 2);
      funct3E = f3; ALU_resultE = a; src2E = s2; ctrlE = ctl;
      @(posedge clk); #1;
      s_valid = 1'b0; memrdE = 1'b0; memwrE = 1'b0; funct3E = 3'($urandom);
      ALU_resultE = $urandom; src2E = $urandom; ctrlE = ~ctl;

      cyc = 1; arv_n = 0; r_n = 0; awv_n = 0; wv_n = 0; b_n = 0;
      while (!m_valid && cyc < 200) begin
         chk("s_ready_busy", s_ready, 0);
         axi.arready = axi.arvalid && (arv_n >= ar_d);
         axi.rvalid  = axi.rready && (r_n >= r_d);
         axi.rdata   = axi.rvalid ? rd : $urandom;
         axi.rresp   = axi.rvalid ? resp : 2'b00;
         axi.awready = axi.awvalid && (awv_n >= aw_d);
         axi.wready  = axi.wvalid && (wv_n >= w_d);
         axi.bvalid  = axi.bready && (b_n >= b_d);
         axi.bresp   = axi.bvalid ? resp : 2'b00;
         if (axi.arvalid) chk("araddr", axi.araddr, a);
         if (axi.awvalid) chk("awaddr", axi.awaddr, a);
         if (axi.wvalid) begin
            chk("wdata", axi.wdata, exp_wd);
            chk("wstrb", axi.wstrb, exp_ws);
         end
         if (axi.bready) chk("bready_after_aw_w", axi.awvalid | axi.wvalid, 0);
         if (axi.arvalid) arv_n++;
         if (axi.rready)  r_n++;
         if (axi.awvalid) awv_n++;
         if (axi.wvalid)  wv_n++;
         if (axi.bready)  b_n++;
         @(posedge clk); #1;
         slave_idle();
         cyc++;
      end
      chk("latency", cyc, exp_lat);
      chk("arvalid_cycles", arv_n, (kind == 1) ? ar_d + 1 : 0);
      chk("awvalid_cycles", awv_n, (kind == 2) ? aw_d + 1 : 0);
      chk("wvalid_cycles",  wv_n,  (kind == 2) ? w_d + 1 : 0);

      for (int i = 0; i <= stall; i++) begin
         chk("m_valid",     m_valid, 1);
         chk("mdataM",      mdataM, exp_md);
         chk("ALU_resultM", ALU_resultM, a);
         chk("src2M",       src2M, s2);
         chk("ctrlM",       ctrlM, ctl);
         chk("faultM",      faultM, exp_f);
         m_ready = (i == stall);
         @(posedge clk); #1;
      end
      m_ready = 1'b0;
      chk("m_valid_drop", m_valid, 0);
      chk("s_ready_back", s_ready, 1);
   endtask

   initial begin
      int guard;
      rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; memrdE = 1'b0; memwrE = 1'b0;
      funct3E = '0; ALU_resultE = '0; src2E = '0; ctrlE = '0;
      slave_idle();
      #3 rst = 1'b0;
      #4;
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_axi_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 0);
      chk("rst_wstrb", axi.wstrb, 0);
      chk("rst_wdata", axi.wdata, 0);
      chk("rst_araddr", axi.araddr, 0);
      chk("rst_data", {mdataM, ALU_resultM, src2M, faultM}, 0);
      chk("rst_ctrlM", ctrlM, 0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      run_op(0, 3'b000, 32'h0000_1234, 32'h5, 32'h0, 2'b00, 0, 0, 0, 0, 0, 5);
      run_op(1, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 2'b00, 0, 0, 0, 0, 0, 0);
      run_op(1, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_1234, 2'b00, 0, 0, 0, 0, 0, 0);
      run_op(1, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_0000, 2'b00, 3, 0, 0, 0, 0, 0);
      run_op(2, 3'b000, 32'h0000_0001, 32'hAB, 32'h0, 2'b00, 0, 0, 0, 3, 0, 0);
      run_op(2, 3'b000, 32'h0000_0001, 32'hAB, 32'h0, 2'b00, 0, 0, 3, 0, 1, 1);
      run_op(1, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2'b10, 0, 1, 0, 0, 0, 0);
      run_op(2, 3'b010, 32'h0000_0204, 32'h1234_5678, 32'h0, 2'b11, 1, 0, 2, 2, 2, 0);
      run_op(2, 3'b001, 32'h0000_0306, 32'hCAFE_9876, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0);

      for (int n = 0; n < 150; n++) begin
         int kind;
         logic [2:0] f3;
         logic [1:0] resp;
         kind = $urandom_range(0, 2);
         f3   = (kind == 2) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
         resp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         run_op(kind, f3, $urandom, $urandom, $urandom, resp,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      // Reset while waiting in R
      s_valid = 1'b1; memrdE = 1'b1; funct3E = 3'b010; ALU_resultE = 32'h40; src2E = '0;
      @(posedge clk); #1;
      s_valid = 1'b0; memrdE = 1'b0;
      axi.arready = 1'b1;
      @(posedge clk); #1;
      axi.arready = 1'b0;
      guard = 0;
      while (!axi.rready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("reach_R", axi.rready, 1);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_rready", axi.rready, 0);
      chk("rst_mid_m_valid", m_valid, 0);
      chk("rst_mid_arvalid", axi.arvalid, 0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_s_ready", s_ready, 1);
      chk("rst_mid_idle_valids", {axi.arvalid, axi.rready, m_valid}, 0);

      run_op(1, 3'b101, 32'h0000_0012, 32'h0, 32'hF00D_8123, 2'b00, 1, 1, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
